// File: rtl/dcache_wb_responder_pkg.sv
// Shared definitions for the write-back D-cache responder: FSM encoding,
// address/line geometry and word select/merge helpers.
package dcache_wb_responder_pkg;

    localparam int ADDR_W      = 30;
    localparam int LINE_ADDR_W = 28;
    localparam int WORD_W      = 32;
    localparam int OFFSET_W    = 2;
    localparam int LINE_W      = 128;
    localparam int IDX_LSB     = OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]   line,
                                                    input logic [OFFSET_W-1:0] off);
        return line[{off, 5'b00000} +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0]   line,
                                                     input logic [OFFSET_W-1:0] off,
                                                     input logic [WORD_W-1:0]   word);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[{off, 5'b00000} +: WORD_W] = word;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-set valid/dirty/tag/data storage. Synchronous write, combinational read.
// Reset clears valid and dirty only; tags and data keep their contents.
module dcache_line_array
    import dcache_wb_responder_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3,
    parameter int TAG_W    = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_we,
    input  logic              i_wdirty,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_data
);

    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [LINE_W-1:0]   r_data [NUM_SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= i_wdirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we && !rst) begin
            r_tag[i_idx]  <= i_wtag;
            r_data[i_idx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_data  = r_data[i_idx];

endmodule

// File: rtl/dcache_wb_responder.sv
// Direct-mapped write-back/write-allocate D-cache controller.
// Define DCACHE_FILL_BYPASS_EN to complete a miss on the fill's mem_ready cycle.
module dcache_wb_responder
    import dcache_wb_responder_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   proc_ren,
    input  logic                   proc_wen,
    input  logic [ADDR_W-1:0]      proc_addr,
    input  logic [WORD_W-1:0]      proc_wdata,
    output logic                   proc_stall,
    output logic [WORD_W-1:0]      proc_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [LINE_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output state_t                 dbg_state
);

    localparam int TAG_W = LINE_ADDR_W - IDX_W;

    // Core handshake: a request (ren|wen) is held stable while proc_stall=1 and
    // is served in the first cycle proc_stall=0; ren&wen together is a write.
    state_t              r_state;
    state_t              w_state_nxt;
    logic [OFFSET_W-1:0] w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_req;
    logic                w_write;
    logic                w_read;
    logic                w_valid;
    logic                w_dirty;
    logic [TAG_W-1:0]    w_ltag;
    logic [LINE_W-1:0]   w_line;
    logic                w_hit;
    logic                w_we;
    logic                w_wdirty;
    logic [LINE_W-1:0]   w_wline;

    assign w_off   = proc_addr[OFFSET_W-1:0];
    assign w_idx   = proc_addr[IDX_LSB +: IDX_W];
    assign w_tag   = proc_addr[ADDR_W-1 -: TAG_W];
    assign w_req   = proc_ren | proc_wen;
    assign w_write = proc_wen;
    assign w_read  = proc_ren & ~proc_wen;
    assign w_hit   = w_valid && (w_ltag == w_tag);

    dcache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .i_idx    (w_idx),
        .i_we     (w_we),
        .i_wdirty (w_wdirty),
        .i_wtag   (w_tag),
        .i_wdata  (w_wline),
        .o_valid  (w_valid),
        .o_dirty  (w_dirty),
        .o_tag    (w_ltag),
        .o_data   (w_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_hit) begin
                    w_state_nxt = (w_valid && w_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: if (mem_ready) w_state_nxt = ST_ALLOCATE;
            ST_ALLOCATE:  if (mem_ready) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory strobes decode only r_state, so they are glitch-free and can never overlap.
    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_we       = 1'b0;
        w_wdirty   = 1'b0;
        w_wline    = mem_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_req && w_hit) begin
                    if (w_write) begin
                        w_we     = 1'b1;
                        w_wdirty = 1'b1;
                        w_wline  = line_merge(w_line, w_off, proc_wdata);
                    end else begin
                        proc_rdata = line_word(w_line, w_off);
                    end
                end else if (w_req) begin
                    proc_stall = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {w_ltag, w_idx};
                mem_wdata  = w_line;
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = {w_tag, w_idx};
                if (mem_ready) begin
                    w_we = 1'b1;
`ifdef DCACHE_FILL_BYPASS_EN
                    proc_stall = 1'b0;
                    if (w_write) begin
                        w_wdirty = 1'b1;
                        w_wline  = line_merge(mem_rdata, w_off, proc_wdata);
                    end else if (w_read) begin
                        proc_rdata = line_word(mem_rdata, w_off);
                    end
`endif
                end
            end
            default: proc_stall = 1'b1;
        endcase
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_dcache_wb_responder.sv
// Self-checking bench for dcache_wb_responder: reference memory plus cache-state
// model feed expected memory transactions and read data into scoreboard queues.
module tb_dcache_wb_responder;
  import dcache_wb_responder_pkg::*;

  localparam int LAT = 3;
`ifdef DCACHE_FILL_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         proc_ren = 1'b0;
  logic         proc_wen = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  state_t       dbg_state;

  logic         resp_ready = 1'b0;
  logic [127:0] resp_data = '0;
  logic         force_ready = 1'b0;
  logic [127:0] force_data = '0;
  int           resp_cnt = 0;

  assign mem_ready = resp_ready | force_ready;
  assign mem_rdata = force_ready ? force_data : resp_data;

  int compared = 0;
  int mismatched = 0;

  logic [156:0] mem_q[$];
  logic [31:0]  rd_q[$];
  logic [127:0] ref_lines[logic [27:0]];
  logic [127:0] mem_lines[logic [27:0]];
  logic         m_valid[8];
  logic         m_dirty[8];
  logic [24:0]  m_tag[8];

  // clock / reset block
  always #5 clk = ~clk;

  dcache_wb_responder #(.NUM_SETS(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dbg_state  (dbg_state)
  );

  function automatic logic [127:0] pat(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) begin
      logic [1:0] w2;
      w2 = w[1:0];
      l[w*32 +: 32] = {la, w2, 2'b01};
    end
    return l;
  endfunction

  function automatic logic [127:0] ref_get(input logic [27:0] la);
    return ref_lines.exists(la) ? ref_lines[la] : pat(la);
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] la);
    return mem_lines.exists(la) ? mem_lines[la] : pat(la);
  endfunction

  // memory responder: answers each request LAT cycles after it appears
  always @(posedge clk) begin
    logic [156:0] exp_t;
    logic [156:0] act_t;
    #1;
    if (resp_ready) begin
      resp_ready = 1'b0;
      resp_data  = '0;
      resp_cnt   = 0;
    end
    compared++;
    if (mem_read === 1'b1 && mem_write === 1'b1) begin
      mismatched++;
      $display("FAIL mem_overlap: mem_read=%b mem_write=%b, required not both high", mem_read, mem_write);
    end
    if (!(mem_read || mem_write)) begin
      resp_cnt = 0;
    end else begin
      resp_cnt++;
      if (resp_cnt == 1) begin
        act_t = {mem_write, mem_addr, mem_write ? mem_wdata : 128'h0};
        compared++;
        if (mem_q.size() == 0) begin
          mismatched++;
          $display("FAIL mem_unexpected: got wr=%b addr=%h, required no request", mem_write, mem_addr);
        end else begin
          exp_t = mem_q.pop_front();
          if (act_t !== exp_t) begin
            mismatched++;
            $display("FAIL mem_txn: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                     act_t[156], act_t[155:128], act_t[127:0], exp_t[156], exp_t[155:128], exp_t[127:0]);
          end
        end
      end
      if (resp_cnt == LAT) begin
        resp_ready = 1'b1;
        if (mem_write) mem_lines[mem_addr] = mem_wdata;
        else resp_data = mem_get(mem_addr);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        logic [2:0]  i3;
        logic [27:0] vla;
        i3  = i[2:0];
        vla = {m_tag[i], i3};
        ref_lines[vla] = mem_get(vla);
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic ren, input logic wen, input logic [29:0] addr,
                              input logic [31:0] wdata, output int exp_stall, output logic exp_miss);
    logic [27:0]  la;
    logic [27:0]  vla;
    logic [2:0]   idx;
    logic [24:0]  tag;
    logic [1:0]   off;
    logic [127:0] line;
    la  = addr[29:2];
    idx = la[2:0];
    tag = la[27:3];
    off = addr[1:0];
    exp_stall = 0;
    exp_miss  = 1'b0;
    if (ren || wen) begin
      if (!(m_valid[idx] && m_tag[idx] == tag)) begin
        exp_miss  = 1'b1;
        exp_stall = 1 + LAT - BYP;
        if (m_valid[idx] && m_dirty[idx]) begin
          vla = {m_tag[idx], idx};
          mem_q.push_back({1'b1, vla, ref_get(vla)});
          exp_stall += LAT;
        end
        mem_q.push_back({1'b0, la, 128'h0});
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_dirty[idx] = 1'b0;
      end
      line = ref_get(la);
      if (wen) begin
        line[off*32 +: 32] = wdata;
        ref_lines[la] = line;
        m_dirty[idx] = 1'b1;
        rd_q.push_back(32'h0);
      end else begin
        rd_q.push_back(line[off*32 +: 32]);
      end
    end else begin
      rd_q.push_back(32'h0);
    end
  endtask

  // driver: issue one core access, hold it until served, check data and latency
  task automatic do_access(input logic ren, input logic wen, input logic [29:0] addr,
                           input logic [31:0] wdata, input string name);
    int          exp_stall;
    int          cyc;
    logic        exp_miss;
    logic [31:0] exp_rd;
    logic        exp_ready;
    model_access(ren, wen, addr, wdata, exp_stall, exp_miss);
    @(posedge clk); #1;
    proc_ren = ren; proc_wen = wen; proc_addr = addr; proc_wdata = wdata;
    @(negedge clk);
    cyc = 0;
    while (proc_stall === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    exp_rd    = rd_q.pop_front();
    exp_ready = exp_miss && (BYP == 1);
    compared++;
    if (proc_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_timeout: stall=%b after %0d cycles, required 0", name, proc_stall, cyc);
    end
    compared++;
    if (cyc !== exp_stall) begin
      mismatched++;
      $display("FAIL %s_latency: stalled %0d cycles, required %0d", name, cyc, exp_stall);
    end
    compared++;
    if (proc_rdata !== exp_rd) begin
      mismatched++;
      $display("FAIL %s_rdata: got %h, required %h", name, proc_rdata, exp_rd);
    end
    compared++;
    if (mem_ready !== exp_ready) begin
      mismatched++;
      $display("FAIL %s_done_on_ready: mem_ready=%b at completion, required %b", name, mem_ready, exp_ready);
    end
    @(posedge clk); #1;
    proc_ren = 1'b0; proc_wen = 1'b0;
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pulse_reset(2);
    @(negedge clk);
    compared++;
    if ({proc_stall, mem_read, mem_write} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_ctrl: stall/rd/wr=%b, required 000", {proc_stall, mem_read, mem_write});
    end
    compared++;
    if (proc_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_rdata: got %h, required 0", proc_rdata);
    end
    compared++;
    if (dbg_state !== ST_IDLE) begin
      mismatched++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_fill_read();
    do_access(1'b1, 1'b0, 30'h0000010, 32'h0, "fill_read");
  endtask

  task automatic test_write_hit();
    do_access(1'b0, 1'b1, 30'h0000011, 32'hDEADBEEF, "write_hit");
    do_access(1'b1, 1'b0, 30'h0000011, 32'h0, "read_after_write");
    do_access(1'b1, 1'b0, 30'h0000010, 32'h0, "read_neighbor_word");
  endtask

  task automatic test_writeback();
    do_access(1'b1, 1'b0, 30'h0000091, 32'h0, "dirty_conflict");
  endtask

  task automatic test_clean_conflict();
    do_access(1'b1, 1'b0, 30'h0000013, 32'h0, "clean_conflict");
  endtask

  task automatic test_both_high();
    do_access(1'b1, 1'b1, 30'h0000012, 32'h12345678, "ren_wen_write");
    do_access(1'b1, 1'b0, 30'h0000012, 32'h0, "ren_wen_readback");
    do_access(1'b0, 1'b0, 30'h0000012, 32'h0, "no_request");
  endtask

  task automatic test_idle_ready();
    @(posedge clk); #1;
    force_ready = 1'b1;
    force_data  = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    force_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (dbg_state !== ST_IDLE || mem_read !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_ready_state: state=%0d mem_read=%b, required %0d/0", dbg_state, mem_read, ST_IDLE);
    end
    do_access(1'b1, 1'b0, 30'h0000012, 32'h0, "idle_ready_ignored");
  endtask

  task automatic test_reset_abort();
    int   es;
    int   cyc;
    logic em;
    logic [31:0] dropped;
    model_access(1'b1, 1'b0, 30'h000001C, 32'h0, es, em);
    @(posedge clk); #1;
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h000001C;
    @(negedge clk);
    cyc = 0;
    while (mem_read !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    compared++;
    if (mem_read !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_alloc_start: mem_read=%b, required 1", mem_read);
    end
    @(posedge clk); #1;
    rst = 1'b1; proc_ren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dropped = rd_q.pop_back();
    model_reset();
    @(negedge clk);
    compared++;
    if ({mem_read, mem_write} !== 2'b00 || dbg_state !== ST_IDLE) begin
      mismatched++;
      $display("FAIL abort_after_reset: rd/wr=%b state=%0d, required 00/%0d", {mem_read, mem_write}, dbg_state, ST_IDLE);
    end
    do_access(1'b1, 1'b0, 30'h000001C, 32'h0, "reread_after_abort");
  endtask

  task automatic test_fill_bypass();
    pulse_reset(1);
    do_access(1'b1, 1'b0, 30'h0000012, 32'h0, "offset_fill_read");
    do_access(1'b0, 1'b1, 30'h0000035, 32'hCAFEF00D, "write_miss");
    do_access(1'b1, 1'b0, 30'h0000035, 32'h0, "write_miss_readback");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [24:0] tag;
      logic [2:0]  idx;
      logic [1:0]  off;
      int          op;
      tag = 25'($urandom_range(0, 3));
      idx = 3'($urandom_range(4, 5));
      off = 2'($urandom_range(0, 3));
      op  = $urandom_range(0, 3);
      do_access(op != 1, op == 1 || op == 2, {tag, idx, off}, $urandom, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    test_reset();
    test_fill_read();
    test_write_hit();
    test_writeback();
    test_clean_conflict();
    test_both_high();
    test_idle_ready();
    test_reset_abort();
    test_fill_bypass();
    test_random();
    repeat (2) @(negedge clk);
    compared++;
    if (mem_q.size() != 0 || rd_q.size() != 0) begin
      mismatched++;
      $display("FAIL queues_drained: mem_q=%0d rd_q=%0d left, required 0/0", mem_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
